// File: rtl/mem_arbiter.sv
// Two-requester memory port arbiter: data path has priority over instruction fetch,
// with a starvation guard, busy backpressure, completion timeout and registered acks.
module mem_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    input  logic              mem_busy,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic              stall,
    output logic              err,
    output logic [2:0]        state
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam int unsigned STK_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_BLOCKED = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT    = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t            r_state, w_next;
    logic              r_owner_i, w_owner_i;
    logic              r_write, w_write;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [DATA_W-1:0] r_wdata, w_wdata;
    logic [DATA_W-1:0] r_rdata, w_rdata;
    logic              r_err_flag, w_err_flag;
    logic [STK_W-1:0]  r_streak, w_streak;
    logic [CNT_W-1:0]  r_cnt, w_cnt;
    logic              r_i_ack, w_i_ack, r_d_ack, w_d_ack;
    logic [DATA_W-1:0] r_i_rdata, w_i_rdata, r_d_rdata, w_d_rdata;
    logic              r_err, w_err;
    logic              r_mem_read, w_mem_read, r_mem_write, w_mem_write;
    logic              w_data_req;

    assign w_data_req = d_read | d_write;

    // State register and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_owner_i   <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_err_flag  <= 1'b0;
            r_streak    <= '0;
            r_cnt       <= '0;
            r_i_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_err       <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_owner_i   <= w_owner_i;
            r_write     <= w_write;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
            r_rdata     <= w_rdata;
            r_err_flag  <= w_err_flag;
            r_streak    <= w_streak;
            r_cnt       <= w_cnt;
            r_i_ack     <= w_i_ack;
            r_d_ack     <= w_d_ack;
            r_i_rdata   <= w_i_rdata;
            r_d_rdata   <= w_d_rdata;
            r_err       <= w_err;
            r_mem_read  <= w_mem_read;
            r_mem_write <= w_mem_write;
        end
    end

    // Next-state, request latch and output decode
    always_comb begin
        w_next      = r_state;
        w_owner_i   = r_owner_i;
        w_write     = r_write;
        w_addr      = r_addr;
        w_wdata     = r_wdata;
        w_rdata     = r_rdata;
        w_err_flag  = r_err_flag;
        w_streak    = r_streak;
        w_cnt       = r_cnt;
        w_i_ack     = 1'b0;
        w_d_ack     = 1'b0;
        w_i_rdata   = '0;
        w_d_rdata   = '0;
        w_err       = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_req || w_data_req) begin
                    // Instruction only wins when alone or after a full data streak
                    w_owner_i = i_req && (!w_data_req || (r_streak == STK_W'(STARVE_LIMIT)));
                    if (w_owner_i) begin
                        w_write  = 1'b0;
                        w_addr   = i_addr;
                        w_wdata  = '0;
                        w_streak = '0;
                    end else begin
                        w_write = !d_read;
                        w_addr  = d_addr;
                        w_wdata = d_read ? '0 : d_wdata;
                        if (!i_req)
                            w_streak = '0;
                        else if (r_streak != STK_W'(STARVE_LIMIT))
                            w_streak = r_streak + STK_W'(1);
                    end
                    w_rdata    = '0;
                    w_err_flag = 1'b0;
                    w_next     = mem_busy ? S_BLOCKED : S_ISSUE;
                end
            end
            S_BLOCKED: begin
                if (!mem_busy)
                    w_next = S_ISSUE;
            end
            S_ISSUE: begin
                w_cnt  = '0;
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (mem_ack) begin
                    w_rdata    = r_write ? '0 : mem_rdata;
                    w_err_flag = 1'b0;
                    w_next     = S_RESP;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_rdata    = '0;
                    w_err_flag = 1'b1;
                    w_next     = S_RESP;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (r_owner_i) begin
                    w_i_ack   = 1'b1;
                    w_i_rdata = r_rdata;
                end else begin
                    w_d_ack   = 1'b1;
                    w_d_rdata = r_rdata;
                end
                w_err  = r_err_flag;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase

        // Strobe is registered on entry so it is high exactly while in ISSUE
        w_mem_read  = (w_next == S_ISSUE) && !w_write;
        w_mem_write = (w_next == S_ISSUE) && w_write;
    end

    assign i_ack     = r_i_ack;
    assign d_ack     = r_d_ack;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign err       = r_err;
    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign state     = r_state;
    assign stall     = rst & ((i_req & ~r_i_ack) | (w_data_req & ~r_d_ack));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: reset, load, precedence/starvation,
// backpressure, timeout and stall behaviour.
module tb_mem_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, d_read, d_write, mem_busy, mem_ack;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic [DW-1:0] d_wdata, mem_rdata, i_rdata, d_rdata, mem_wdata;
    logic          i_ack, d_ack, mem_read, mem_write, stall, err;
    logic [2:0]    state;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_busy(mem_busy), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
        .stall(stall), .err(err), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; i_req = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_busy = 1'b0; mem_ack = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        tick(); tick();
        n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", state); end
        n_tests++; if ({i_ack, d_ack, i_rdata, d_rdata, mem_addr, mem_wdata, mem_read, mem_write, stall, err} !== '0) begin
            n_fail++; $display("FAIL reset_outputs got nonzero exp all 0"); end
        rst = 1'b1; i_req = 1'b1; i_addr = 32'h100;
        tick(); tick(); tick(); tick();
        n_tests++; if (state !== 3'd3) begin n_fail++; $display("FAIL reset_prewait_state got %0d exp 3", state); end
        #2 rst = 1'b0;
        #1;
        n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_async_state got %0d exp 0", state); end
        n_tests++; if ({i_ack, d_ack, i_rdata, d_rdata, mem_addr, mem_wdata, mem_read, mem_write, stall, err} !== '0) begin
            n_fail++; $display("FAIL reset_async_outputs got nonzero exp all 0"); end
        i_req = 1'b0;
        tick();
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_tests++; if ({i_ack, d_ack, state} !== 5'd0) begin
                n_fail++; $display("FAIL reset_no_ack cyc %0d got ack=%b/%b state=%0d exp 0", k, i_ack, d_ack, state); end
        end
    endtask

    task automatic test_idle();
        mem_ack = 1'b1; mem_rdata = 32'h1111;
        for (int k = 0; k < 5; k++) begin
            mem_busy = k[0];
            tick();
            n_tests++; if ({state, stall, i_ack, d_ack, mem_read, mem_write} !== 8'd0) begin
                n_fail++; $display("FAIL idle_quiet cyc %0d got state=%0d stall=%b acks=%b%b exp all 0", k, state, stall, i_ack, d_ack); end
        end
        mem_ack = 1'b0; mem_busy = 1'b0; mem_rdata = '0;
    endtask

    task automatic test_load();
        d_read = 1'b1; d_addr = 32'h40;
        tick();
        n_tests++; if ({state, mem_read, mem_write} !== {3'd2, 2'b10}) begin
            n_fail++; $display("FAIL load_issue got state=%0d rd=%b wr=%b exp 2 1 0", state, mem_read, mem_write); end
        n_tests++; if (mem_addr !== 32'h40 || mem_wdata !== 32'h0) begin
            n_fail++; $display("FAIL load_addr got %h/%h exp 00000040/00000000", mem_addr, mem_wdata); end
        tick();
        n_tests++; if ({state, mem_read, d_ack} !== {3'd3, 2'b00} || mem_addr !== 32'h40) begin
            n_fail++; $display("FAIL load_wait got state=%0d rd=%b ack=%b addr=%h exp 3 0 0 40", state, mem_read, d_ack, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        n_tests++; if ({state, d_ack} !== {3'd4, 1'b0}) begin
            n_fail++; $display("FAIL load_resp got state=%0d ack=%b exp 4 0", state, d_ack); end
        tick();
        n_tests++; if (d_ack !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL load_ack got ack=%b rdata=%h exp 1 deadbeef", d_ack, d_rdata); end
        n_tests++; if ({i_ack, err, stall} !== 3'b000 || i_rdata !== 32'h0) begin
            n_fail++; $display("FAIL load_side got i_ack=%b err=%b stall=%b i_rdata=%h exp 0 0 0 0", i_ack, err, stall, i_rdata); end
        d_read = 1'b0;
        tick();
        n_tests++; if ({d_ack, state} !== 4'd0) begin
            n_fail++; $display("FAIL load_after got ack=%b state=%0d exp 0 0", d_ack, state); end
    endtask

    task automatic test_precedence();
        logic        exp_i;
        logic [31:0] exp_addr, val;
        i_req = 1'b1; d_read = 1'b1; d_write = 1'b1;
        i_addr = 32'h1000; d_addr = 32'h2000; d_wdata = 32'h55;
        for (int g = 0; g < 5; g++) begin
            exp_i    = (g == 4);
            exp_addr = exp_i ? 32'h1000 : 32'h2000;
            val      = 32'hA0 + 32'(g);
            tick();
            n_tests++; if ({state, mem_read, mem_write} !== {3'd2, 2'b10} || mem_addr !== exp_addr) begin
                n_fail++; $display("FAIL prec_grant%0d got state=%0d rd=%b wr=%b addr=%h exp 2 1 0 %h", g, state, mem_read, mem_write, mem_addr, exp_addr); end
            tick();
            mem_ack = 1'b1; mem_rdata = val;
            tick();
            mem_ack = 1'b0; mem_rdata = '0;
            tick();
            n_tests++; if ({i_ack, d_ack} !== {exp_i, ~exp_i}) begin
                n_fail++; $display("FAIL prec_ack%0d got i=%b d=%b exp i=%b d=%b", g, i_ack, d_ack, exp_i, ~exp_i); end
            n_tests++; if (i_rdata !== (exp_i ? val : 32'h0) || d_rdata !== (exp_i ? 32'h0 : val)) begin
                n_fail++; $display("FAIL prec_rdata%0d got i=%h d=%h val=%h owner_i=%b", g, i_rdata, d_rdata, val, exp_i); end
        end
        i_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
        tick();
        n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL prec_end_state got %0d exp 0", state); end
    endtask

    task automatic test_backpressure();
        d_write = 1'b1; d_addr = 32'h80; d_wdata = 32'h1234; mem_busy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_tests++; if ({state, mem_read, mem_write} !== {3'd1, 2'b00}) begin
                n_fail++; $display("FAIL bp_blocked cyc %0d got state=%0d rd=%b wr=%b exp 1 0 0", k, state, mem_read, mem_write); end
        end
        mem_busy = 1'b0;
        tick();
        n_tests++; if ({state, mem_write, mem_read} !== {3'd2, 2'b10} || mem_wdata !== 32'h1234 || mem_addr !== 32'h80) begin
            n_fail++; $display("FAIL bp_issue got state=%0d wr=%b rd=%b wdata=%h addr=%h exp 2 1 0 1234 80", state, mem_write, mem_read, mem_wdata, mem_addr); end
        mem_busy = 1'b1;
        tick();
        n_tests++; if ({state, mem_write} !== {3'd3, 1'b0} || mem_wdata !== 32'h1234) begin
            n_fail++; $display("FAIL bp_single_pulse got state=%0d wr=%b wdata=%h exp 3 0 1234", state, mem_write, mem_wdata); end
        mem_ack = 1'b1; mem_rdata = 32'hFFFF;
        tick();
        mem_ack = 1'b0; mem_rdata = '0; mem_busy = 1'b0;
        tick();
        n_tests++; if (d_ack !== 1'b1 || d_rdata !== 32'h0 || err !== 1'b0) begin
            n_fail++; $display("FAIL bp_ack got ack=%b rdata=%h err=%b exp 1 0 0", d_ack, d_rdata, err); end
        d_write = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        i_req = 1'b1; i_addr = 32'h300;
        tick(); tick();
        for (int k = 0; k < int'(TO) - 1; k++) tick();
        n_tests++; if (state !== 3'd3) begin n_fail++; $display("FAIL to_still_wait got %0d exp 3", state); end
        tick();
        n_tests++; if ({state, i_ack} !== {3'd4, 1'b0}) begin
            n_fail++; $display("FAIL to_resp got state=%0d ack=%b exp 4 0", state, i_ack); end
        tick();
        n_tests++; if ({i_ack, err} !== 2'b11 || i_rdata !== 32'h0) begin
            n_fail++; $display("FAIL to_err got ack=%b err=%b rdata=%h exp 1 1 0", i_ack, err, i_rdata); end
        i_req = 1'b0;
        tick();
        n_tests++; if ({i_ack, err} !== 2'b00) begin
            n_fail++; $display("FAIL to_err_pulse got ack=%b err=%b exp 0 0", i_ack, err); end
        i_req = 1'b1;
        tick(); tick();
        for (int k = 0; k < int'(TO) - 1; k++) tick();
        mem_ack = 1'b1; mem_rdata = 32'hCAFE0001;
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        tick();
        n_tests++; if ({i_ack, err} !== 2'b10 || i_rdata !== 32'hCAFE0001) begin
            n_fail++; $display("FAIL to_ack_wins got ack=%b err=%b rdata=%h exp 1 0 cafe0001", i_ack, err, i_rdata); end
        i_req = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        bit done = 1'b0;
        d_read = 1'b1; d_addr = 32'h44;
        #1;
        n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL stall_initial got %b exp 1", stall); end
        for (int k = 0; k < 20 && !done; k++) begin
            mem_ack = (state == 3'd3);
            mem_rdata = 32'h77;
            tick();
            if (d_ack === 1'b1) begin
                done = 1'b1;
                n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL stall_ack_cycle got %b exp 0", stall); end
            end else begin
                n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL stall_pending cyc %0d got %b exp 1", k, stall); end
            end
        end
        mem_ack = 1'b0;
        n_tests++; if (!done) begin n_fail++; $display("FAIL stall_ack_timeout got no ack exp ack within 20 cycles"); end
        d_read = 1'b0;
        tick();
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL stall_released got %b exp 0", stall); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_load();
        test_precedence();
        test_backpressure();
        test_timeout();
        test_stall();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish exp finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
